// File: rtl/motor_pkg.sv
// Shared definitions for the wheel-motor control slice: channel count,
// encoder I2C addresses and the angle read scheduler state encoding.
package motor_pkg;

  localparam int         NUM_CH        = 4;
  localparam logic [6:0] DEV_ADDR_DFLT = 7'h36;
  localparam logic [7:0] REG_ADDR_DFLT = 8'h0C;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    START,
    WAIT,
    UPDATE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first enabled channel after last_ch,
// wrapping 3 -> 0; last_ch itself is only chosen when it is the sole one enabled.
module rr_pick (
  input  logic [3:0] enable_mask,
  input  logic [1:0] last_ch,
  output logic [1:0] next_ch,
  output logic       valid
);

  logic [1:0] w_idx;

  // Walk from farthest to nearest so the nearest enabled channel is the last write.
  always_comb begin
    next_ch = last_ch;
    valid   = 1'b0;
    w_idx   = last_ch;
    for (int i = 4; i >= 1; i--) begin
      w_idx = last_ch + 2'(i);
      if (enable_mask[w_idx]) begin
        next_ch = w_idx;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/angle_read_scheduler.sv
// Shares one I2C master and a 1-of-4 bus mux among the wheel-angle encoders,
// polling enabled channels round-robin and latching each 12-bit angle.
module angle_read_scheduler
  import motor_pkg::*;
#(
  parameter int         NUM_CH         = motor_pkg::NUM_CH,
  parameter logic [6:0] DEV_ADDR       = DEV_ADDR_DFLT,
  parameter logic [7:0] REG_ADDR       = REG_ADDR_DFLT,
  parameter int         MUX_SETTLE     = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    enable_mask,
  input  logic                 clear_err,
  input  logic                 i2c_busy,
  input  logic                 i2c_done,
  input  logic                 i2c_error,
  input  logic [15:0]          i2c_rdata,
  output logic                 i2c_start,
  output logic                 i2c_abort,
  output logic [6:0]           i2c_dev_addr,
  output logic [7:0]           i2c_reg_addr,
  output logic [1:0]           ch_sel,
  output logic [12*NUM_CH-1:0] angle,
  output logic [NUM_CH-1:0]    rd_done,
  output logic [NUM_CH-1:0]    err_sticky,
  output logic                 busy
);

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_last_ch, r_ch_sel;
  logic [15:0]           r_settle_cnt, r_tmo_cnt;
  logic                  r_rd_err;
  logic [11:0]           r_rd_data;
  logic [12*NUM_CH-1:0]  r_angle;
  logic [NUM_CH-1:0]     r_rd_done, r_err_sticky, w_err_set;
  logic [1:0]            w_next_ch;
  logic                  w_valid, w_timeout, w_ch_en;

  rr_pick u_rr_pick (
    .enable_mask (enable_mask),
    .last_ch     (r_last_ch),
    .next_ch     (w_next_ch),
    .valid       (w_valid)
  );

  assign w_timeout = (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
  // A channel dropped from the mask mid-read has its result discarded.
  assign w_ch_en   = enable_mask[r_ch_sel];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    i2c_start   = 1'b0;
    i2c_abort   = 1'b0;
    w_err_set   = '0;
    case (r_state)
      IDLE:   if (w_valid && !i2c_busy) w_state_nxt = SETTLE;
      SETTLE: begin
        if (enable_mask == '0)         w_state_nxt = IDLE;
        else if (r_settle_cnt == 16'd0) w_state_nxt = START;
      end
      START: begin
        i2c_start   = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (i2c_done) begin
          w_state_nxt = UPDATE;
        end else if (w_timeout) begin
          i2c_abort   = 1'b1;
          w_state_nxt = IDLE;
          if (w_ch_en) w_err_set[r_ch_sel] = 1'b1;
        end
      end
      UPDATE: begin
        w_state_nxt = IDLE;
        if (w_ch_en && r_rd_err) w_err_set[r_ch_sel] = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments and an async active-low reset; last_ch starts at 3 so channel 0 goes first.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_last_ch    <= 2'd3;
      r_ch_sel     <= 2'd0;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_rd_err     <= 1'b0;
      r_rd_data    <= '0;
      r_angle      <= '0;
      r_rd_done    <= '0;
      r_err_sticky <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_done    <= '0;
      // An error set in the same cycle as clear_err survives.
      r_err_sticky <= (clear_err ? '0 : r_err_sticky) | w_err_set;
      case (r_state)
        IDLE: begin
          if (w_state_nxt == SETTLE) begin
            r_ch_sel     <= w_next_ch;
            r_last_ch    <= w_next_ch;
            r_settle_cnt <= 16'(MUX_SETTLE - 1);
          end
        end
        SETTLE: if (r_settle_cnt != 16'd0) r_settle_cnt <= r_settle_cnt - 16'd1;
        START:  r_tmo_cnt <= '0;
        WAIT: begin
          if (i2c_done) begin
            r_rd_err  <= i2c_error;
            r_rd_data <= i2c_rdata[11:0];
          end else if (r_tmo_cnt != 16'hFFFF) begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        UPDATE: begin
          if (w_ch_en && !r_rd_err) begin
            r_angle[12*int'(r_ch_sel) +: 12] <= r_rd_data;
            r_rd_done[r_ch_sel]              <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign i2c_dev_addr = DEV_ADDR;
  assign i2c_reg_addr = REG_ADDR;
  assign ch_sel       = r_ch_sel;
  assign angle        = r_angle;
  assign rd_done      = r_rd_done;
  assign err_sticky   = r_err_sticky;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_angle_read_scheduler.sv
// Self-checking bench for angle_read_scheduler: randomized I2C responses
// scored against a behavioural round-robin model of channels, angles and errors.
module tb_angle_read_scheduler;

  localparam int M = 16;
  localparam int T = 200;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  enable_mask = 4'b0;
  logic        clear_err = 1'b0;
  logic        i2c_busy = 1'b1;
  logic        i2c_done = 1'b0;
  logic        i2c_error = 1'b0;
  logic [15:0] i2c_rdata = 16'h0;
  logic        i2c_start, i2c_abort, busy;
  logic [6:0]  i2c_dev_addr;
  logic [7:0]  i2c_reg_addr;
  logic [1:0]  ch_sel;
  logic [47:0] angle;
  logic [3:0]  rd_done, err_sticky;

  angle_read_scheduler #(.MUX_SETTLE(M), .TIMEOUT_CYCLES(T)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable_mask  (enable_mask),
    .clear_err    (clear_err),
    .i2c_busy     (i2c_busy),
    .i2c_done     (i2c_done),
    .i2c_error    (i2c_error),
    .i2c_rdata    (i2c_rdata),
    .i2c_start    (i2c_start),
    .i2c_abort    (i2c_abort),
    .i2c_dev_addr (i2c_dev_addr),
    .i2c_reg_addr (i2c_reg_addr),
    .ch_sel       (ch_sel),
    .angle        (angle),
    .rd_done      (rd_done),
    .err_sticky   (err_sticky),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic [11:0] m_angle [4];
  logic [3:0]  m_err;
  int          m_last;

  function automatic int pick(input logic [3:0] mask, input int last);
    for (int i = 1; i <= 4; i++)
      if (mask[(last + i) % 4]) return (last + i) % 4;
    return -1;
  endfunction

  function automatic logic [47:0] m_vec();
    return {m_angle[3], m_angle[2], m_angle[1], m_angle[0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_angle[i] = 12'h000;
    m_err  = 4'b0;
    m_last = 3;
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic wait_start(output bit ok, output int z, output int s);
    ok = 1'b0; z = -1; s = 0;
    if (busy === 1'b0) z = cyc;
    i2c_busy = 1'b0;
    for (int k = 0; k < M + 50; k++) begin
      tick();
      if (i2c_start === 1'b1) begin
        ok = 1'b1;
        s  = cyc;
        break;
      end
    end
  endtask

  task automatic serve(input string tag, input int lat, input bit err, input logic [11:0] data,
                       input bit data_is_ch, input bit respond, input bit drop_ch);
    int exp_ch, z, s;
    bit ok, got, saw_abort, en;
    logic [11:0] d;
    logic [3:0]  exp_rd;
    exp_ch = pick(enable_mask, m_last);
    m_last = exp_ch;
    d      = data_is_ch ? 12'(12'h100 + exp_ch) : data;
    exp_rd = 4'b0;
    wait_start(ok, z, s);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s start: got no i2c_start within %0d cycles, want one", tag, M + 50);
      return;
    end
    i2c_busy = 1'b1;
    n_vec++;
    if (ch_sel !== 2'(exp_ch)) begin
      n_bad++;
      $display("FAIL %s ch_sel: got %0d want %0d", tag, ch_sel, exp_ch);
    end
    if (z >= 0) begin
      n_vec++;
      if (s - z != M + 1) begin
        n_bad++;
        $display("FAIL %s start_latency: got %0d want %0d", tag, s - z, M + 1);
      end
    end
    if (drop_ch) enable_mask[exp_ch] = 1'b0;
    tick();
    n_vec++;
    if (i2c_start !== 1'b0) begin
      n_bad++;
      $display("FAIL %s start_width: got i2c_start=%b want 0", tag, i2c_start);
    end
    if (!respond) begin
      got = 1'b0;
      for (int k = 0; k < T + 20; k++) begin
        if (i2c_abort === 1'b1) begin
          got = 1'b1;
          break;
        end
        tick();
      end
      n_vec++;
      if (!got || (cyc - s != T)) begin
        n_bad++;
        $display("FAIL %s abort_time: got seen=%0d after %0d cycles want %0d", tag, got, cyc - s, T);
      end
      if (enable_mask[exp_ch]) m_err[exp_ch] = 1'b1;
      tick();
      n_vec++;
      if ({err_sticky, angle, busy, i2c_abort} !== {m_err, m_vec(), 1'b0, 1'b0}) begin
        n_bad++;
        $display("FAIL %s after_abort: got err=%b angle=%h busy=%b abort=%b want err=%b angle=%h busy=0 abort=0",
                 tag, err_sticky, angle, busy, i2c_abort, m_err, m_vec());
      end
      return;
    end
    saw_abort = 1'b0;
    for (int k = 1; k < lat; k++) begin
      if (i2c_abort === 1'b1) saw_abort = 1'b1;
      tick();
    end
    i2c_done  = 1'b1;
    i2c_error = err;
    i2c_rdata = {4'($urandom), d};
    #1;
    if (i2c_abort === 1'b1) saw_abort = 1'b1;
    n_vec++;
    if (saw_abort) begin
      n_bad++;
      $display("FAIL %s early_abort: got i2c_abort before done, want none (lat=%0d)", tag, lat);
    end
    tick();
    i2c_done  = 1'b0;
    i2c_error = 1'b0;
    n_vec++;
    if (rd_done !== 4'b0) begin
      n_bad++;
      $display("FAIL %s rd_done_early: got %b want 0000", tag, rd_done);
    end
    en = enable_mask[exp_ch];
    if (en && !err) begin
      m_angle[exp_ch] = d;
      exp_rd[exp_ch]  = 1'b1;
    end else if (en) begin
      m_err[exp_ch] = 1'b1;
    end
    tick();
    n_vec++;
    if ({rd_done, angle, err_sticky, busy} !== {exp_rd, m_vec(), m_err, 1'b0}) begin
      n_bad++;
      $display("FAIL %s update: got rd=%b angle=%h err=%b busy=%b want rd=%b angle=%h err=%b busy=0",
               tag, rd_done, angle, err_sticky, busy, exp_rd, m_vec(), m_err);
    end
    tick();
    n_vec++;
    if (rd_done !== 4'b0) begin
      n_bad++;
      $display("FAIL %s rd_done_width: got %b want 0000", tag, rd_done);
    end
  endtask

  task automatic test_reset();
    model_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_vec++;
    if ({i2c_start, i2c_abort, rd_done, angle, err_sticky, ch_sel, busy, i2c_dev_addr, i2c_reg_addr}
        !== {1'b0, 1'b0, 4'b0, 48'h0, 4'b0, 2'd0, 1'b0, 7'h36, 8'h0C}) begin
      n_bad++;
      $display("FAIL reset: got start=%b abort=%b rd=%b angle=%h err=%b ch=%0d busy=%b dev=%h reg=%h want zeros, dev=36 reg=0c",
               i2c_start, i2c_abort, rd_done, angle, err_sticky, ch_sel, busy, i2c_dev_addr, i2c_reg_addr);
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    enable_mask = 4'b1111;
    for (int i = 0; i < 5; i++) serve("rr", $urandom_range(1, 8), 1'b0, 12'h0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_single();
    enable_mask = 4'b0100;
    for (int i = 0; i < 3; i++) serve("single", $urandom_range(1, 8), 1'b0, 12'($urandom), 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_busy_hold();
    bit saw;
    enable_mask = 4'b0001;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0 || i2c_start !== 1'b0) saw = 1'b1;
    end
    n_vec++;
    if (saw) begin
      n_bad++;
      $display("FAIL busy_hold: got activity while i2c_busy=1, want IDLE");
    end
  endtask

  task automatic test_timeout();
    enable_mask = 4'b0011;
    serve("timeout", 0, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
    serve("after_timeout", $urandom_range(1, 8), 1'b0, 12'($urandom), 1'b0, 1'b1, 1'b0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    m_err     = 4'b0;
    tick();
    n_vec++;
    if (err_sticky !== m_err) begin
      n_bad++;
      $display("FAIL clear_err: got %b want %b", err_sticky, m_err);
    end
  endtask

  task automatic test_simultaneous();
    enable_mask = 4'b1111;
    serve("done_at_timeout", T, 1'b0, 12'h5A5, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_error();
    enable_mask = 4'b0010;
    serve("err_ch1", $urandom_range(1, 8), 1'b1, 12'hEEE, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_disable();
    enable_mask = 4'b1000;
    serve("disable_ch3", $urandom_range(2, 8), 1'b0, 12'hABC, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_done_outside();
    enable_mask = 4'b0000;
    i2c_busy    = 1'b0;
    i2c_done    = 1'b1;
    i2c_rdata   = 16'hFFFF;
    tick();
    i2c_done = 1'b0;
    tick();
    n_vec++;
    if ({rd_done, angle, busy} !== {4'b0, m_vec(), 1'b0}) begin
      n_bad++;
      $display("FAIL done_outside: got rd=%b angle=%h busy=%b want rd=0000 angle=%h busy=0", rd_done, angle, busy, m_vec());
    end
    i2c_busy = 1'b1;
  endtask

  task automatic test_settle_abort();
    bit saw;
    enable_mask = 4'b0010;
    m_last      = pick(enable_mask, m_last);
    i2c_busy    = 1'b0;
    repeat (3) tick();
    n_vec++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL settle_entry: got busy=%b want 1", busy);
    end
    enable_mask = 4'b0000;
    saw = 1'b0;
    for (int i = 0; i < M + 5; i++) begin
      tick();
      if (i2c_start === 1'b1) saw = 1'b1;
    end
    n_vec++;
    if (saw || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL settle_abort: got start_seen=%b busy=%b want 0 0", saw, busy);
    end
    i2c_busy = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      enable_mask = 4'($urandom_range(1, 15));
      serve("random", $urandom_range(1, 8), ($urandom_range(0, 5) == 0), 12'($urandom), 1'b0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int z, s;
    bit ok;
    enable_mask = 4'b1111;
    m_last      = pick(enable_mask, m_last);
    wait_start(ok, z, s);
    i2c_busy = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if ({i2c_start, i2c_abort, rd_done, angle, err_sticky, ch_sel, busy} !== {1'b0, 1'b0, 4'b0, 48'h0, 4'b0, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid: got start=%b abort=%b rd=%b angle=%h err=%b ch=%0d busy=%b want all zero (start seen=%b)",
               i2c_start, i2c_abort, rd_done, angle, err_sticky, ch_sel, busy, ok);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    serve("post_reset", $urandom_range(1, 8), 1'b0, 12'h321, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running at 500000, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_busy_hold();
    test_timeout();
    test_simultaneous();
    test_error();
    test_disable();
    test_done_outside();
    test_settle_abort();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/angle_read_scheduler.md
# angle_read_scheduler

Round-robin scheduler that shares a single I2C master, and a 1-of-4 I2C bus mux, among the four wheel-angle encoders. Each encoder has the same device address, so the mux separates them. For each enabled channel the block sequences mux select, settle, read start and completion/timeout handling, then latches the 12-bit angle. It drives that channel's `current_angle` and a one-cycle `rd_done` pulse into the per-wheel PID controller.

## Interface
Parameters:
- `NUM_CH`, 4: encoder channels; fixed at 4 for this revision.
- `DEV_ADDR`, 7'h36: encoder I2C device address.
- `REG_ADDR`, 8'h0C: raw-angle register address.
- `MUX_SETTLE`, 16: clock cycles to wait after a `ch_sel` change before starting a read.
- `TIMEOUT_CYCLES`, 50000: maximum number of cycles spent in WAIT before the read is aborted.

Ports:
- `clock`  in  1  main clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable_mask`  in  4  per-channel poll enable.
- `clear_err`  in  1  clears `err_sticky` (level).
- `i2c_busy`  in  1  I2C master busy.
- `i2c_done`  in  1  one-cycle pulse: transaction complete.
- `i2c_error`  in  1  NACK/bus error; qualified by `i2c_done`.
- `i2c_rdata`  in  16  read data; angle in `[11:0]`.
- `i2c_start`  out  1  one-cycle start pulse.
- `i2c_abort`  out  1  one-cycle abort pulse.
- `i2c_dev_addr`  out  7  always `DEV_ADDR`.
- `i2c_reg_addr`  out  8  always `REG_ADDR`.
- `ch_sel`  out  2  I2C mux select.
- `angle`  out  48  channel n is `angle[12n+11:12n]`.
- `rd_done`  out  4  one-cycle pulse per channel on a valid update.
- `err_sticky`  out  4  per-channel error or timeout seen.
- `busy`  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: wait until `enable_mask` is nonzero and `i2c_busy` is 0. Then pick the next channel, drive `ch_sel`, load the settle counter and go to SETTLE.
  - SETTLE: count down `MUX_SETTLE` cycles, then go to START.
  - START: assert `i2c_start` for exactly one cycle, clear the timeout counter and go to WAIT.
  - WAIT: on `i2c_done`, go to UPDATE. If the timeout counter reaches `TIMEOUT_CYCLES - 1`, pulse `i2c_abort`, set `err_sticky[ch]` and return to IDLE.
  - UPDATE: if `i2c_error` was captured with `i2c_done`, set `err_sticky[ch]` and leave the angle unchanged. Otherwise write `i2c_rdata[11:0]` into the channel's angle slot and pulse `rd_done[ch]`. Then go to IDLE.
- Channel pick:
  - Search starts at `last_ch + 1`, mod 4, and returns the first set bit of `enable_mask`.
  - Wrap-around 3 → 0 is required.
  - If only one channel is enabled, it is re-selected every round.
- `last_ch` updates when a channel is picked, including reads that later time out or error.
- A channel disabled while its read is in flight completes normally, but the result is discarded: no angle write, no `rd_done`, no error set.
- Simultaneous events:
  - `i2c_done` and timeout in the same cycle: done wins, and the read is treated as completed.
  - `clear_err` and an error set for the same bit: set wins.
- `i2c_done` outside WAIT is ignored.
- If `enable_mask` becomes 0 in SETTLE, the block returns to IDLE without asserting `i2c_start`.

## Timing
- Reset values:
  - `i2c_start`, `i2c_abort`, `rd_done`: 0.
  - `angle`, `err_sticky`: 0.
  - `ch_sel`: 0, with `last_ch` = 3 so channel 0 is served first.
  - `busy`: 0; state is IDLE.
- Reset asserted mid-transaction returns the block to IDLE immediately and does not pulse `i2c_abort`.
- `ch_sel` changes on the IDLE→SETTLE edge and is stable through WAIT and UPDATE.
- `i2c_start` is high in the cycle the state is START, which is `MUX_SETTLE` + 1 cycles after leaving IDLE.
- The `angle` slot and `rd_done[ch]` update together, one cycle after `i2c_done` is sampled. `rd_done` is high for exactly 1 cycle.
- Minimum time between two channel reads is `MUX_SETTLE` + 4 + the I2C transaction time.
- The timeout counter is 16 bits and saturates; it must not wrap.

## Structure
- Shared package `motor_pkg`: state enum (IDLE, SETTLE, START, WAIT, UPDATE), `NUM_CH`, and default `DEV_ADDR` / `REG_ADDR` constants.
- Sub-module `rr_pick`: combinational next-channel picker. Inputs `enable_mask[3:0]` and `last_ch[1:0]`; outputs `next_ch[1:0]` and `valid`.

## Test plan
- `enable_mask` = 4'b1111 and an I2C model returning 12'h100 + ch → `ch_sel` order is 0,1,2,3,0. Each `angle` slot equals 12'h10n, each `rd_done[n]` is a single pulse, and `err_sticky` stays 0.
- `enable_mask` = 4'b0100 → every read uses `ch_sel` = 2; `rd_done[2]` only.
- Model never returns `i2c_done` → `i2c_abort` pulses `TIMEOUT_CYCLES` cycles after `i2c_start`, `err_sticky[ch]` = 1, `angle` is unchanged, and the next channel is served. `clear_err` then returns `err_sticky` to 0.
- `i2c_done` with `i2c_error` = 1 on channel 1 → `err_sticky[1]` = 1, no `rd_done[1]`, and the old angle is retained.
- Channel 3 is disabled during WAIT, then the read returns 12'hABC → `angle[47:36]` is unchanged and there is no `rd_done[3]`.
- `reset_n` is asserted during WAIT → all outputs return to their reset values. After release, the first `ch_sel` is 0 and a new `i2c_start` follows after `MUX_SETTLE` + 1 cycles.
